ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Shares the single RAMControl command port between several requesters: network evaluation, DNA initializer, sort and crossover engines. Each requester raises a request carrying instruction, address and write data. The arbiter grants one requester at a time, issues exactly one `ramLatch` pulse to RAMControl, follows `ramReady` through the access and returns an ack pulse with read data. It sits between the requesters and RAMControl in the top module and replaces the direct multi-driver connection of `ramInstruction`, `ramLatch`, `ramBusAddr` and `ramBusDataIn`.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 23, RAM word address width (MemAdr[23:1])
- DATA_W, 16, RAM data width

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester request level
- req_instr  in  NUM_REQ  per-requester instruction; READ=0, WRITE=1
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester
- grant  out  NUM_REQ  one-hot; high from ISSUE through ACK inclusive
- rdata  out  DATA_W  read data captured at completion
- ramInstruction  out  1  to RAMControl
- ramLatch  out  1  one-cycle command strobe to RAMControl
- ramBusAddr  out  ADDR_W  to RAMControl
- ramBusDataIn  out  DATA_W  write data to RAMControl
- ramBusDataOut  in  DATA_W  read data from RAMControl
- ramReady  in  1  RAMControl idle/complete indication

## Operation
- FSM states: IDLE, ISSUE, BUSY, WAIT, ACK.
- IDLE: when `ramReady`=1 and any `req` is set, pick a winner, register its instr/addr/wdata into the ram* outputs, set `grant`, and go to ISSUE. If `ramReady`=0, stay in IDLE.
- ISSUE: `ramLatch`=1 for exactly this cycle; go to BUSY.
- BUSY: wait for `ramReady`=0, then go to WAIT.
- WAIT: wait for `ramReady`=1; on that cycle capture `ramBusDataOut` into `rdata` (reads only; writes leave `rdata` unchanged) and go to ACK.
- ACK: `ack[winner]`=1 for one cycle; update the round-robin pointer to the winner; go to IDLE.
- Round-robin: search starts at pointer+1 modulo NUM_REQ. The pointer resets to NUM_REQ-1, so requester 0 wins first after reset.
- Requester rule: hold `req` and its fields stable until `ack`, then drop `req` or present a new command in the next cycle.
- The arbiter ignores `req` in the ACK cycle. A request still high in IDLE after its ack is treated as a new request.
- `req` dropped before grant: no access, no ack.
- `req` dropped after grant: the access completes and `ack` still pulses.
- Non-winner requests stay pending; no request is lost.
- ram* command outputs hold their values from IDLE exit until the next grant.

## Timing
- Reset values: state IDLE, ack=0, grant=0, rdata=0, ramInstruction=0, ramLatch=0, ramBusAddr=0, ramBusDataIn=0, pointer=NUM_REQ-1.
- Reset mid-access: the FSM returns to IDLE immediately and the access is abandoned with no ack. RAMControl is not reset by this block.
- Request sampled at edge 0 gives `ramLatch` in cycle 1. Minimum req-to-ack latency is 4 cycles plus RAMControl busy time.
- One access in flight at most; `ramLatch` never asserts outside ISSUE.

## Configuration
- RAM_ARB_FIXED_PRIORITY_EN defined: fixed priority, lowest index wins. The pointer register is removed and `grant` ordering never rotates.
- Undefined (default): round-robin as described above.

## Structure
- Package `ram_arb_pkg` holds: READ/WRITE constants, the state enum (IDLE..ACK), and default ADDR_W/DATA_W.
- Sub-module `rr_picker`: combinational, takes the req vector and pointer and returns a one-hot winner plus its index. It implements both the round-robin and fixed-priority forms under the macro.

## Test plan
- Single write: req[1], WRITE, addr 0x000010, wdata 0xBEEF -> `ramLatch` one cycle with addr 0x000010 and data 0xBEEF; ack[1] after `ramReady` returns high.
- Single read: model returns 0x1234 -> ack[2] with rdata=0x1234 in the same cycle.
- Contention: req[0..3] held high continuously -> grant order 0,1,2,3,0. With RAM_ARB_FIXED_PRIORITY_EN defined -> requester 0 is granted repeatedly.
- `ramReady` low in IDLE with req[0] high -> no `ramLatch` until `ramReady` rises; then the normal access proceeds.
- rst asserted during WAIT -> all outputs zero the same cycle, no ack; after release, a pending req[3] is granted only after req[0] if both are high.
- req[2] dropped one cycle after grant -> the access still completes and ack[2] pulses once.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared constants and FSM state type for the RAMControl command-port arbiter.
package ram_arb_pkg;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam int DEF_ADDR_W = 23;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, WAIT, ACK} arbStateT;

endpackage

// File: rtl/rr_picker.sv
// Combinational winner select: round-robin from ptr+1, or lowest index first
// when RAM_ARB_FIXED_PRIORITY_EN is defined (no pointer input in that build).
module rr_picker
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
`ifndef RAM_ARB_FIXED_PRIORITY_EN
  input  logic [IDX_W-1:0]   ptr,
`endif
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winIdx,
  output logic               anyReq
);

  assign anyReq = |req;

`ifdef RAM_ARB_FIXED_PRIORITY_EN
  always_comb begin
    winner = '0;
    winIdx = '0;
    // Scan high to low so the lowest set index is the last (winning) write.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner    = '0;
        winner[i] = 1'b1;
        winIdx    = IDX_W'(i);
      end
    end
  end
`else
  always_comb begin
    int cand;
    cand   = 0;
    winner = '0;
    winIdx = '0;
    // Scan from the farthest candidate back to ptr+1 so the nearest one wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (req[cand]) begin
        winner       = '0;
        winner[cand] = 1'b1;
        winIdx       = IDX_W'(cand);
      end
    end
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Grants the single RAMControl command port to one requester at a time.
// Define RAM_ARB_FIXED_PRIORITY_EN for fixed lowest-index-first priority.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_instr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        grant,
  output logic [DATA_W-1:0]         rdata,
  output logic                      ramInstruction,
  output logic                      ramLatch,
  output logic [ADDR_W-1:0]         ramBusAddr,
  output logic [DATA_W-1:0]         ramBusDataIn,
  input  logic [DATA_W-1:0]         ramBusDataOut,
  input  logic                      ramReady
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arbStateT           state, stateNext;
  logic [NUM_REQ-1:0] winner;
  logic [IDX_W-1:0]   winIdx;
  logic               anyReq;
  logic               launch;
  logic               capture;

`ifndef RAM_ARB_FIXED_PRIORITY_EN
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   grantIdx;
`endif

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) uPicker (
    .req    (req),
`ifndef RAM_ARB_FIXED_PRIORITY_EN
    .ptr    (ptr),
`endif
    .winner (winner),
    .winIdx (winIdx),
    .anyReq (anyReq)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    launch    = 1'b0;
    capture   = 1'b0;
    ramLatch  = 1'b0;
    ack       = '0;
    case (state)
      IDLE: begin
        if (ramReady && anyReq) begin
          launch    = 1'b1;
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        ramLatch  = 1'b1;
        stateNext = BUSY;
      end
      BUSY: begin
        if (!ramReady) stateNext = WAIT;
      end
      WAIT: begin
        if (ramReady) begin
          capture   = 1'b1;
          stateNext = ACK;
        end
      end
      ACK: begin
        ack       = grant;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Command fields are frozen at grant so requesters may drop req mid-access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant          <= '0;
      rdata          <= '0;
      ramInstruction <= READ;
      ramBusAddr     <= '0;
      ramBusDataIn   <= '0;
`ifndef RAM_ARB_FIXED_PRIORITY_EN
      ptr            <= IDX_W'(NUM_REQ - 1);
      grantIdx       <= '0;
`endif
    end else begin
      if (launch) begin
        grant          <= winner;
        ramInstruction <= req_instr[winIdx];
        ramBusAddr     <= req_addr[int'(winIdx)*ADDR_W +: ADDR_W];
        ramBusDataIn   <= req_wdata[int'(winIdx)*DATA_W +: DATA_W];
`ifndef RAM_ARB_FIXED_PRIORITY_EN
        grantIdx       <= winIdx;
`endif
      end
      if (capture && ramInstruction != WRITE) rdata <= ramBusDataOut;
      if (state == ACK) begin
        grant <= '0;
`ifndef RAM_ARB_FIXED_PRIORITY_EN
        ptr   <= grantIdx;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small behavioural RAMControl model.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 23;
  localparam int DATA_W  = 16;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        reqInstr;
  logic [NUM_REQ*ADDR_W-1:0] reqAddr;
  logic [NUM_REQ*DATA_W-1:0] reqWdata;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        grant;
  logic [DATA_W-1:0]         rdata;
  logic                      ramInstruction;
  logic                      ramLatch;
  logic [ADDR_W-1:0]         ramBusAddr;
  logic [DATA_W-1:0]         ramBusDataIn;
  logic [DATA_W-1:0]         ramBusDataOut;
  logic                      ramReady;

  ram_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_instr      (reqInstr),
    .req_addr       (reqAddr),
    .req_wdata      (reqWdata),
    .ack            (ack),
    .grant          (grant),
    .rdata          (rdata),
    .ramInstruction (ramInstruction),
    .ramLatch       (ramLatch),
    .ramBusAddr     (ramBusAddr),
    .ramBusDataIn   (ramBusDataIn),
    .ramBusDataOut  (ramBusDataOut),
    .ramReady       (ramReady)
  );

  always #5 clk = ~clk;

  // RAMControl model: drops ready after a latch, stays busy busyLen cycles.
  logic holdLow  = 1'b0;
  int   busyLen  = 3;
  int   busyLeft = 0;
  initial begin
    ramReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (holdLow) ramReady = 1'b0;
      else if (ramLatch) begin
        ramReady = 1'b0;
        busyLeft = busyLen;
      end else if (!ramReady) begin
        if (busyLeft == 0) ramReady = 1'b1;
        else busyLeft--;
      end
    end
  end

  int assertCount = 0;
  int failCount   = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic setReq(input int idx, input logic instr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
    reqInstr[idx]                  = instr;
    reqAddr[idx*ADDR_W +: ADDR_W]  = a;
    reqWdata[idx*DATA_W +: DATA_W] = d;
    req[idx]                       = 1'b1;
  endtask

  logic [NUM_REQ-1:0] ackSeen, grantSeen;
  logic [DATA_W-1:0]  rdataSeen, latchData;
  logic [ADDR_W-1:0]  latchAddr;
  logic               latchInstr;
  int                 latchN, latchCyc, ackCyc;

  task automatic runUntilAck(input string tag, input int maxCyc);
    ackSeen  = '0;
    latchN   = 0;
    latchCyc = -1;
    ackCyc   = -1;
    for (int c = 1; c <= maxCyc; c++) begin
      @(negedge clk);
      if (ramLatch) begin
        latchN++;
        latchCyc   = c;
        latchAddr  = ramBusAddr;
        latchData  = ramBusDataIn;
        latchInstr = ramInstruction;
      end
      if (ack != '0) begin
        ackSeen   = ack;
        grantSeen = grant;
        rdataSeen = rdata;
        ackCyc    = c;
        break;
      end
    end
    checkVal({tag, "AckArrived"}, 32'(ackCyc > 0), 32'd1);
  endtask

  int expOrder [5];
  int cnt, cnt2, found;

  initial begin
`ifdef RAM_ARB_FIXED_PRIORITY_EN
    expOrder = '{0, 0, 0, 0, 0};
`else
    expOrder = '{0, 1, 2, 3, 0};
`endif
    rst = 1'b1;
    req = '0;
    reqInstr = '0;
    reqAddr = '0;
    reqWdata = '0;
    ramBusDataOut = '0;
    repeat (3) @(negedge clk);
    checkVal("rstAck", 32'(ack), 32'd0);
    checkVal("rstGrant", 32'(grant), 32'd0);
    checkVal("rstLatch", 32'(ramLatch), 32'd0);
    checkVal("rstAddr", 32'(ramBusAddr), 32'd0);
    checkVal("rstDataIn", 32'(ramBusDataIn), 32'd0);
    checkVal("rstInstr", 32'(ramInstruction), 32'd0);
    checkVal("rstRdata", 32'(rdata), 32'd0);
    rst = 1'b0;

    // Single write from requester 1
    setReq(1, WRITE, 23'h000010, 16'hBEEF);
    runUntilAck("wr", 30);
    checkVal("wrAck", 32'(ackSeen), 32'h2);
    checkVal("wrGrant", 32'(grantSeen), 32'h2);
    checkVal("wrLatchCount", 32'(latchN), 32'd1);
    checkVal("wrLatchCycle", 32'(latchCyc), 32'd1);
    checkVal("wrAddr", 32'(latchAddr), 32'h10);
    checkVal("wrData", 32'(latchData), 32'hBEEF);
    checkVal("wrInstr", 32'(latchInstr), 32'(WRITE));
    checkVal("wrRdataKept", 32'(rdataSeen), 32'd0);
    req = '0;
    @(negedge clk);
    checkVal("wrAckOnePulse", 32'(ack), 32'd0);

    // Single read from requester 2
    ramBusDataOut = 16'h1234;
    setReq(2, READ, 23'h000020, 16'h0000);
    runUntilAck("rd", 30);
    checkVal("rdAck", 32'(ackSeen), 32'h4);
    checkVal("rdRdata", 32'(rdataSeen), 32'h1234);
    checkVal("rdInstr", 32'(latchInstr), 32'(READ));
    checkVal("rdAddr", 32'(latchAddr), 32'h20);
    req = '0;
    @(negedge clk);

    // Contention after a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) setReq(i, WRITE, ADDR_W'(i * 256), DATA_W'(16'hC000 + i));
    for (int n = 0; n < 5; n++) begin
      runUntilAck($sformatf("rr%0d", n), 30);
      checkVal($sformatf("rrAck%0d", n), 32'(ackSeen), 32'd1 << expOrder[n]);
      checkVal($sformatf("rrAddr%0d", n), 32'(latchAddr), 32'(expOrder[n] * 256));
      checkVal($sformatf("rrLatches%0d", n), 32'(latchN), 32'd1);
    end
    req = '0;

    // ramReady held low while a request waits in IDLE
    holdLow = 1'b1;
    repeat (2) @(negedge clk);
    setReq(0, WRITE, 23'h000040, 16'h5555);
    cnt = 0;
    cnt2 = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ramLatch) cnt++;
      if (grant != '0) cnt2++;
    end
    checkVal("lowNoLatch", 32'(cnt), 32'd0);
    checkVal("lowNoGrant", 32'(cnt2), 32'd0);
    holdLow = 1'b0;
    runUntilAck("low", 30);
    checkVal("lowAck", 32'(ackSeen), 32'h1);
    checkVal("lowLatchCount", 32'(latchN), 32'd1);
    checkVal("lowAddr", 32'(latchAddr), 32'h40);
    req = '0;
    @(negedge clk);

    // Reset asserted while requester 3's read is in WAIT
    ramBusDataOut = 16'h7777;
    setReq(3, READ, 23'h000300, 16'h0000);
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      @(negedge clk);
      if (ramLatch) found = 1;
    end
    checkVal("w5LatchSeen", 32'(found), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    setReq(0, WRITE, 23'h0000AB, 16'h00AB);
    #1;
    checkVal("w5RstAck", 32'(ack), 32'd0);
    checkVal("w5RstGrant", 32'(grant), 32'd0);
    checkVal("w5RstLatch", 32'(ramLatch), 32'd0);
    checkVal("w5RstAddr", 32'(ramBusAddr), 32'd0);
    checkVal("w5RstDataIn", 32'(ramBusDataIn), 32'd0);
    checkVal("w5RstInstr", 32'(ramInstruction), 32'd0);
    checkVal("w5RstRdata", 32'(rdata), 32'd0);
    @(negedge clk);
    checkVal("w5NoAckInRst", 32'(ack), 32'd0);
    rst = 1'b0;
    runUntilAck("w5a", 40);
    checkVal("w5FirstAck", 32'(ackSeen), 32'h1);
    req[0] = 1'b0;
    runUntilAck("w5b", 40);
    checkVal("w5SecondAck", 32'(ackSeen), 32'h8);
    checkVal("w5Rdata", 32'(rdataSeen), 32'h7777);
    req = '0;
    @(negedge clk);

    // Requester 2 drops req one cycle after grant
    ramBusDataOut = 16'hA5A5;
    setReq(2, READ, 23'h000222, 16'h0000);
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      @(negedge clk);
      if (grant[2]) found = 1;
    end
    checkVal("dropGrantSeen", 32'(found), 32'd1);
    @(negedge clk);
    req[2] = 1'b0;
    runUntilAck("drop", 30);
    checkVal("dropAck", 32'(ackSeen), 32'h4);
    checkVal("dropRdata", 32'(rdataSeen), 32'hA5A5);
    cnt = 0;
    cnt2 = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ack != '0) cnt++;
      if (ramLatch) cnt2++;
    end
    checkVal("dropNoExtraAck", 32'(cnt), 32'd0);
    checkVal("dropNoExtraLatch", 32'(cnt2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, assertions %0d failures %0d", assertCount, failCount);
    $fatal(1);
  end

endmodule
